// File: rtl/trackball_counter.sv
// rtl/trackball_counter.sv - dual trackball quadrature counter with CPU latches (optional glitch filter: TRACKBALL_FILTER_EN)
module trackball_counter (
  input  logic       CLK5n,
  input  logic       RESET,
  input  logic [3:0] QUAD1,
  input  logic [3:0] QUAD2,
  input  logic       SHFT0,
  input  logic       SHFT1,
  input  logic       CK1,
  input  logic       LD1n,
  input  logic       LD2n,
  input  logic       CL1n,
  input  logic       CL2n,
  output logic [7:0] TRACK_X,
  output logic [7:0] TRACK_Y
);

  // Gray table: 00->01->11->10->00 counts up, the reverse counts down,
  // a double-bit change is treated as noise.
  function automatic logic signed [1:0] quad_step(input logic [1:0] old_ba,
                                                  input logic [1:0] new_ba);
    case ({old_ba, new_ba})
      4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: quad_step = 2'sd1;
      4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: quad_step = -2'sd1;
      default:                                quad_step = 2'sd0;
    endcase
  endfunction

  // Pending accumulator add, clamped to the 4-bit signed range.
  function automatic logic signed [3:0] sat_add(input logic signed [3:0] acc,
                                                input logic signed [1:0] inc);
    logic signed [4:0] sum;
    sum = {acc[3], acc} + {{3{inc[1]}}, inc};
    if (sum > 5'sd7)
      sat_add = 4'sd7;
    else if (sum < -5'sd8)
      sat_add = -4'sd8;
    else
      sat_add = sum[3:0];
  endfunction

  logic              sel_q;
  logic              sel_next;
  logic [1:0]        resync_cnt;
  logic              resyncing;
  logic [3:0]        src;
  logic [3:0]        sync1;
  logic [3:0]        sync2;
  logic [3:0]        dec_in;
  logic [3:0]        prev;
  logic              ck1_s;
  logic              ck1_q;
  logic              ck1_rise;
  logic signed [1:0] step_x;
  logic signed [1:0] step_y;
  logic signed [3:0] pend_x;
  logic signed [3:0] pend_y;
  logic [7:0]        cnt_x;
  logic [7:0]        cnt_y;

  assign src       = sel_q ? QUAD2 : QUAD1;
  assign resyncing = (resync_cnt != 2'd0);
  assign ck1_rise  = ck1_s & ~ck1_q;

  // Source selection: QUAD1 has priority, both deasserted keeps the last choice.
  always_comb begin
    sel_next = sel_q;
    if (!SHFT0)
      sel_next = 1'b0;
    else if (!SHFT1)
      sel_next = 1'b1;
  end

`ifdef TRACKBALL_FILTER_EN
  logic [3:0] hist0;
  logic [3:0] hist1;
  logic [3:0] filt_q;
  logic [3:0] stable;

  // A bit is accepted only once three consecutive synchronized samples agree.
  always_comb begin
    stable = ~(sync2 ^ hist0) & ~(hist0 ^ hist1);
    dec_in = (stable & sync2) | (~stable & filt_q);
  end

  // Sample history and accepted value; the accepted value is forced during resync.
  always_ff @(posedge CLK5n) begin
    if (RESET) begin
      hist0  <= QUAD1;
      hist1  <= QUAD1;
      filt_q <= QUAD1;
    end else begin
      hist0  <= sync2;
      hist1  <= hist0;
      filt_q <= resyncing ? sync2 : dec_in;
    end
  end
`else
  // Without the filter the decoder looks straight at the synchronizer output.
  always_comb begin
    dec_in = sync2;
  end
`endif

  // Steps are suppressed while the previous-state registers settle on a new source.
  always_comb begin
    step_x = 2'sd0;
    step_y = 2'sd0;
    if (!resyncing) begin
      step_x = quad_step(prev[1:0], dec_in[1:0]);
      step_y = quad_step(prev[3:2], dec_in[3:2]);
    end
  end

  // Front end: selection, resync window, synchronizer and previous-state registers.
  always_ff @(posedge CLK5n) begin
    if (RESET) begin
      sel_q      <= 1'b0;
      resync_cnt <= 2'd0;
      sync1      <= QUAD1;
      sync2      <= QUAD1;
      prev       <= QUAD1;
    end else begin
      sel_q <= sel_next;
      if (sel_next != sel_q)
        resync_cnt <= 2'd3;
      else if (resyncing)
        resync_cnt <= resync_cnt - 2'd1;
      sync1 <= src;
      sync2 <= sync1;
      prev  <= resyncing ? sync2 : dec_in;
    end
  end

  // CK1 is synchronized and edge-detected; history starts high so release is quiet.
  always_ff @(posedge CLK5n) begin
    if (RESET) begin
      ck1_s <= 1'b1;
      ck1_q <= 1'b1;
    end else begin
      ck1_s <= CK1;
      ck1_q <= ck1_s;
    end
  end

  // X axis: latch old count, then clear, commit or accumulate.
  always_ff @(posedge CLK5n) begin
    if (RESET) begin
      cnt_x   <= 8'd0;
      pend_x  <= 4'sd0;
      TRACK_X <= 8'd0;
    end else begin
      if (!LD1n)
        TRACK_X <= cnt_x;
      if (!CL1n) begin
        cnt_x  <= 8'd0;
        pend_x <= 4'sd0;
      end else if (ck1_rise) begin
        cnt_x  <= cnt_x + {{4{pend_x[3]}}, pend_x};
        pend_x <= {{2{step_x[1]}}, step_x};
      end else begin
        pend_x <= sat_add(pend_x, step_x);
      end
    end
  end

  // Y axis: latch old count, then clear, commit or accumulate.
  always_ff @(posedge CLK5n) begin
    if (RESET) begin
      cnt_y   <= 8'd0;
      pend_y  <= 4'sd0;
      TRACK_Y <= 8'd0;
    end else begin
      if (!LD2n)
        TRACK_Y <= cnt_y;
      if (!CL2n) begin
        cnt_y  <= 8'd0;
        pend_y <= 4'sd0;
      end else if (ck1_rise) begin
        cnt_y  <= cnt_y + {{4{pend_y[3]}}, pend_y};
        pend_y <= {{2{step_y[1]}}, step_y};
      end else begin
        pend_y <= sat_add(pend_y, step_y);
      end
    end
  end

endmodule
